// File: rtl/guess_round_ctrl.sv
// Round controller for the math-game comparator: draws a secret target from a
// free-running LFSR, counts guesses and reports win/loss status.
module guess_round_ctrl #(
    parameter logic [6:0] SEED         = 7'h5A,
    parameter int         MAX_VALUE    = 99,
    parameter int         MAX_ATTEMPTS = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       new_round_btn_i,
    input  logic       guess_submit_i,
    input  logic       equal_i,
    output logic [6:0] rand_o,
    output logic       rand_valid_o,
    output logic [3:0] attempts_o,
    output logic       round_won_o,
    output logic       round_lost_o,
    output logic       busy_o
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] DRAW = 3'd1;
    localparam logic [2:0] PLAY = 3'd2;
    localparam logic [2:0] WON  = 3'd3;
    localparam logic [2:0] LOST = 3'd4;

    localparam logic [6:0] SEED_EFF  = (SEED == 7'd0) ? 7'h01 : SEED;
    localparam logic [6:0] MAX_VAL_W = MAX_VALUE[6:0];
    localparam logic [3:0] MAX_ATT_W = MAX_ATTEMPTS[3:0];

    logic [2:0] state_q,      state_d;
    logic [6:0] lfsr_q,       lfsr_d;
    logic       btn_prev_q;
    logic [6:0] rand_q,       rand_d;
    logic       rand_valid_q, rand_valid_d;
    logic [3:0] attempts_q,   attempts_d;
    logic       won_q,        won_d;
    logic       lost_q,       lost_d;
    logic       rise;
    logic       sample_ok;

    assign rise      = new_round_btn_i & ~btn_prev_q;
    assign sample_ok = (lfsr_q != 7'd0) && (lfsr_q <= MAX_VAL_W);
    assign lfsr_d    = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

    // A button rise overrides everything else, including a guess in the same cycle.
    always_comb begin
        state_d      = state_q;
        rand_d       = rand_q;
        rand_valid_d = rand_valid_q;
        attempts_d   = attempts_q;
        won_d        = won_q;
        lost_d       = lost_q;
        if (rise) begin
            state_d      = DRAW;
            rand_valid_d = 1'b0;
            attempts_d   = 4'd0;
            won_d        = 1'b0;
            lost_d       = 1'b0;
        end else begin
            case (state_q)
                DRAW: begin
                    if (sample_ok) begin
                        rand_d       = lfsr_q;
                        rand_valid_d = 1'b1;
                        state_d      = PLAY;
                    end
                end
                PLAY: begin
                    if (guess_submit_i) begin
                        attempts_d = attempts_q + 4'd1;
                        if (equal_i) begin
                            state_d = WON;
                            won_d   = 1'b1;
                        end else if (attempts_q + 4'd1 == MAX_ATT_W) begin
                            state_d = LOST;
                            lost_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            lfsr_q       <= SEED_EFF;
            btn_prev_q   <= 1'b0;
            rand_q       <= 7'd0;
            rand_valid_q <= 1'b0;
            attempts_q   <= 4'd0;
            won_q        <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            btn_prev_q   <= new_round_btn_i;
            rand_q       <= rand_d;
            rand_valid_q <= rand_valid_d;
            attempts_q   <= attempts_d;
            won_q        <= won_d;
            lost_q       <= lost_d;
        end
    end

    assign rand_o       = rand_q;
    assign rand_valid_o = rand_valid_q;
    assign attempts_o   = attempts_q;
    assign round_won_o  = won_q;
    assign round_lost_o = lost_q;
    assign busy_o       = (state_q == DRAW);

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Self-checking bench for guess_round_ctrl: directed test-plan scenarios plus
// randomized traffic, all compared against a round-level reference model.
module tb_guess_round_ctrl;

    localparam int TB_SEED         = 1;
    localparam int TB_MAX_VALUE    = 20;
    localparam int TB_MAX_ATTEMPTS = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       newRoundBtn = 1'b0;
    logic       guessSubmit = 1'b0;
    logic       equal = 1'b0;
    logic [6:0] randOut;
    logic       randValid;
    logic [3:0] attempts;
    logic       roundWon;
    logic       roundLost;
    logic       busy;

    int compareCount = 0;
    int failCount    = 0;

    // Reference model: round-level view of the game
    int mLfsr, mRand, mAttempts;
    bit mBtnPrev, mValid, mWon, mLost, mDrawing;

    guess_round_ctrl #(
        .SEED(7'(TB_SEED)), .MAX_VALUE(TB_MAX_VALUE), .MAX_ATTEMPTS(TB_MAX_ATTEMPTS)
    ) dut (
        .clk_i(clk), .rst_i(rst), .new_round_btn_i(newRoundBtn),
        .guess_submit_i(guessSubmit), .equal_i(equal),
        .rand_o(randOut), .rand_valid_o(randValid), .attempts_o(attempts),
        .round_won_o(roundWon), .round_lost_o(roundLost), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Advances the model by one clock given the inputs presented this cycle.
    task automatic modelStep(input bit r, input bit b, input bit s, input bit e);
        bit rise;
        if (r) begin
            mLfsr = (TB_SEED == 0) ? 1 : TB_SEED;
            mBtnPrev = 0; mRand = 0; mValid = 0; mAttempts = 0;
            mWon = 0; mLost = 0; mDrawing = 0;
            return;
        end
        rise = b && !mBtnPrev;
        if (rise) begin
            mDrawing = 1; mValid = 0; mAttempts = 0; mWon = 0; mLost = 0;
        end else if (mDrawing) begin
            if (mLfsr >= 1 && mLfsr <= TB_MAX_VALUE) begin
                mRand = mLfsr; mValid = 1; mDrawing = 0;
            end
        end else if (mValid && !mWon && !mLost && s) begin
            mAttempts = mAttempts + 1;
            if (e) mWon = 1;
            else if (mAttempts == TB_MAX_ATTEMPTS) mLost = 1;
        end
        mBtnPrev = b;
        mLfsr = ((mLfsr * 2) % 128) + (((mLfsr / 64) % 2) ^ ((mLfsr / 32) % 2));
    endtask

    task automatic checkAll();
        checkOutput("rand", randOut, mRand);
        checkOutput("rand_valid", randValid, mValid);
        checkOutput("attempts", attempts, mAttempts);
        checkOutput("round_won", roundWon, mWon);
        checkOutput("round_lost", roundLost, mLost);
        checkOutput("busy", busy, mDrawing);
    endtask

    task automatic applyStimulus(input bit r, input bit b, input bit s, input bit e);
        rst = r; newRoundBtn = b; guessSubmit = s; equal = e;
        modelStep(r, b, s, e);
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic idle(input int n, input bit b);
        for (int i = 0; i < n; i++) applyStimulus(0, b, 0, 0);
    endtask

    task automatic startRound();
        int budget;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        budget = 0;
        while (!mValid && budget < 200) begin
            applyStimulus(0, 0, 0, 0);
            budget++;
        end
        checkOutput("draw_timeout", budget < 200, 1);
    endtask

    initial begin
        bit btnLevel;

        // Rise in cycle 0 after reset: target 2 from cycle 2
        applyStimulus(1, 0, 0, 0);
        checkOutput("reset_valid", randValid, 0);
        checkOutput("reset_busy", busy, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("s1_busy", busy, 1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("s1_rand", randOut, 2);
        checkOutput("s1_valid", randValid, 1);

        // Rise in cycle 5: 65 rejected, 3 accepted
        applyStimulus(1, 0, 0, 0);
        idle(5, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("s2_busy6", busy, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("s2_busy7", busy, 1);
        checkOutput("s2_valid7", randValid, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("s2_rand", randOut, 3);
        checkOutput("s2_valid8", randValid, 1);
        checkOutput("s2_busy8", busy, 0);

        // Win on fourth guess, then further guesses ignored
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("win_attempts", attempts, 4);
        checkOutput("win_flag", roundWon, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("win_frozen", attempts, 4);

        // Eight misses lose; a ninth is ignored
        startRound();
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0);
        checkOutput("lose_flag", roundLost, 1);
        checkOutput("lose_attempts", attempts, 8);
        applyStimulus(0, 0, 1, 0);
        checkOutput("lose_frozen", attempts, 8);

        // Win on the last allowed guess beats exhaustion
        startRound();
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("last_win", roundWon, 1);
        checkOutput("last_notlost", roundLost, 0);

        // Rise together with a guess, then button held for 50 cycles
        startRound();
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("sim_att2", attempts, 2);
        applyStimulus(0, 1, 1, 0);
        checkOutput("sim_att0", attempts, 0);
        checkOutput("sim_valid", randValid, 0);
        checkOutput("sim_busy", busy, 1);
        idle(49, 1);
        checkOutput("held_valid", randValid, 1);
        applyStimulus(0, 1, 1, 0);
        checkOutput("held_att", attempts, 1);

        // Reset mid-DRAW and mid-PLAY, same timing replayed each time
        applyStimulus(1, 0, 0, 0);
        idle(3, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("rst_draw_busy", busy, 0);
        idle(3, 0);
        applyStimulus(0, 1, 0, 0);
        idle(10, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("rst_play_att", attempts, 0);
        checkOutput("rst_play_rand", randOut, 0);
        idle(3, 0);
        applyStimulus(0, 1, 0, 0);
        idle(10, 0);

        // Randomized traffic
        btnLevel = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit r, s, e;
            if (!btnLevel) btnLevel = ($urandom_range(0, 59) == 0);
            else           btnLevel = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 399) == 0);
            s = ($urandom_range(0, 2) == 0);
            e = ($urandom_range(0, 5) == 0);
            applyStimulus(r, btnLevel, s, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/guess_round_ctrl.md
Name: guess_round_ctrl

Overview:
- Round controller that sits directly upstream of the math-game comparator.
- Generates the 7-bit secret target for the comparator's rand input using a free-running LFSR with rejection sampling, and holds it stable for a whole round.
- Counts player guess submissions, using the comparator's equal feedback to declare a win or a loss.
- Drives the round-status outputs consumed by the display/LED logic.

Parameters:
- SEED, 7'h5A, LFSR value loaded at reset; if SEED==0 the LFSR loads 7'h01 instead.
- MAX_VALUE, 99, largest target accepted (1..127).
- MAX_ATTEMPTS, 8, guesses allowed per round (1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- new_round_btn  in  1  level, already synchronised; a rising edge starts or restarts a round.
- guess_submit  in  1  one-cycle pulse; the player's guess is being presented to the comparator this cycle.
- equal  in  1  comparator equal output (guess==rand), sampled only when guess_submit=1.
- rand  out  7  target value to comparator; stable while rand_valid=1.
- rand_valid  out  1  target latched, round in play.
- attempts  out  4  guesses consumed this round.
- round_won  out  1  level, held until next round starts.
- round_lost  out  1  level, held until next round starts.
- busy  out  1  high in DRAW state.

Behaviour:
- Reset (rst=1 at a clock edge): lfsr=SEED (or 7'h01), state=IDLE, btn_prev=0, rand=0, rand_valid=0, attempts=0, round_won=0, round_lost=0, busy=0. rst takes priority over all other inputs.
- LFSR:
  - Fibonacci, x^7+x^6+1: fb=q[6]^q[5], next={q[5:0],fb}, period 127, never 0.
  - Steps every cycle in every state except reset.
  - Cycle k after reset release holds the k-th successor of the seed; cycle 0 holds the seed. Example seed 1 gives 1,2,4,8,16,32,65,3,6,...
- Edge detect: btn_prev<=new_round_btn each cycle; rise = new_round_btn & ~btn_prev.
- States: IDLE, DRAW, PLAY, WON, LOST.
  - Any state, rise in cycle t: next state is DRAW at t+1.
    - rand_valid, attempts, round_won and round_lost are cleared at t+1.
    - rand holds its old value until the new target is accepted.
  - DRAW: busy=1. If 1<=lfsr<=MAX_VALUE, then rand<=lfsr, rand_valid<=1, go to PLAY. Otherwise stay; the next cycle tests the next LFSR value.
    - Latency: an accepted sample in cycle t+1 appears on rand in cycle t+2.
    - Worst-case DRAW is 127 cycles.
  - PLAY, guess_submit=1:
    - attempts<=attempts+1.
    - If equal=1: go to WON, round_won<=1.
    - Else if attempts+1==MAX_ATTEMPTS: go to LOST, round_lost<=1.
    - Else stay in PLAY.
    - The win check has priority over exhausting attempts on the same guess.
  - WON/LOST: rand and rand_valid hold, attempts frozen. guess_submit and equal are ignored. Leave only on rise.
  - IDLE/DRAW/WON/LOST: guess_submit ignored, attempts unchanged.
- Simultaneous events: rise and guess_submit in the same cycle in PLAY: rise wins, the guess is discarded and attempts clears.
- Holding new_round_btn high starts exactly one round.
- round_won and round_lost are never both 1.
- attempts never exceeds MAX_ATTEMPTS.
- Reset mid-DRAW or mid-PLAY returns everything to the reset values. The LFSR restarts from the seed.

Test Plan:
- SEED=1, MAX_VALUE=99: release rst, btn rises in cycle 0 -> busy=1 in cycle 1, rand=2 and rand_valid=1 from cycle 2, attempts=0.
- SEED=1, MAX_VALUE=20: btn rises in cycle 5 -> DRAW sees 65 in cycle 6 (rejected) and 3 in cycle 7 -> rand=3, rand_valid=1 in cycle 8. busy high for cycles 6-7.
- In PLAY, MAX_ATTEMPTS=8: 3 guess_submit pulses with equal=0, then 1 with equal=1 -> attempts=4, round_won=1, state WON. Further pulses leave attempts=4.
- MAX_ATTEMPTS=8: 8 pulses with equal=0 -> round_lost=1 after the 8th and attempts=8. A 9th pulse is ignored. The 8th pulse with equal=1 instead -> round_won=1.
- In PLAY with attempts=2, btn rise together with guess_submit -> next cycle DRAW, attempts=0, rand_valid=0; a new target is latched afterwards. btn held high for 50 cycles starts only one round.
- rst asserted mid-DRAW and mid-PLAY -> all outputs at reset values next cycle. The LFSR sequence restarts at the seed, so an identical btn timing reproduces an identical rand.
